// File: rtl/imm_encoder.sv
// RV32I immediate encoder: packs format/field inputs into an instruction word,
// expanding the li pseudo-instruction into LUI+ADDI when needed.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        err,
  output logic        last
);

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] enc_inst, enc_pend, li_sum;
  logic        enc_err, enc_last, enc_split;
  logic        i_ok, b_ok, j_ok;
  logic        accept, consume;

  always_comb begin
    li_sum    = imm + 32'h0000_0800;
    i_ok      = (&imm[31:11]) | ~(|imm[31:11]);
    b_ok      = (&imm[31:12]) | ~(|imm[31:12]);
    j_ok      = (&imm[31:20]) | ~(|imm[31:20]);
    enc_inst  = '0;
    enc_pend  = '0;
    enc_err   = 1'b0;
    enc_last  = 1'b1;
    enc_split = 1'b0;
    case (fmt)
      3'd0: begin
        enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = ~i_ok;
      end
      3'd1: begin
        enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = ~i_ok;
      end
      3'd2: begin
        enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = ~b_ok | imm[0];
      end
      3'd3: begin
        enc_inst = {imm[19:0], rd, opcode};
        enc_err  = |imm[31:20];
      end
      3'd4: begin
        enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = ~j_ok | imm[0];
      end
      3'd5: begin
        if (i_ok) begin
          enc_inst = {imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else begin
          // hi is rounded so the sign-extended ADDI of lo lands back on imm
          enc_inst  = {li_sum[31:12], rd, 7'h37};
          enc_pend  = {imm[11:0], rd, 3'b000, rd, 7'h13};
          enc_split = |imm[11:0];
          enc_last  = ~(|imm[11:0]);
        end
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    err_d       = err_q;
    last_d      = last_q;
    pend_d      = pend_q;
    if (consume) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          inst_d      = enc_inst;
          err_d       = enc_err;
          last_d      = enc_last;
          if (enc_split) begin
            pend_d  = enc_pend;
            state_d = LI_LO;
          end
        end
      end
      LI_LO: begin
        if (consume) begin
          if (!last_q) begin
            out_valid_d = 1'b1;
            inst_d      = pend_q;
            err_d       = 1'b0;
            last_d      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
    end
  end

  assign out_valid = out_valid_q;
  assign inst      = inst_q;
  assign err       = err_q;
  assign last      = last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed cases from the plan plus
// randomized requests checked against an arithmetic reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] inst;
  logic        err;
  logic        last;

  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .err(err), .last(last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [33:0] sbq[$];
  bit rdy_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic e, input logic l);
    sbq.push_back({i, e, l});
  endtask

  // Reference: field placement by shifts/masks and range tests on signed values.
  task automatic model_push(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [31:0] im);
    int s;
    logic [31:0] w, hi, lo, base;
    s = int'(im);
    base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      3'd0: push(((im & 32'hFFF) << 20) | base | (32'(d) << 7), !(s >= -2048 && s <= 2047), 1'b1);
      3'd1: push((((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base | ((im & 32'h1F) << 7),
                 !(s >= -2048 && s <= 2047), 1'b1);
      3'd2: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (32'(s2) << 20) | base |
            (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7);
        push(w, (s < -4096) || (s > 4095) || (im % 2 == 1), 1'b1);
      end
      3'd3: push(((im & 32'hFFFFF) << 12) | (32'(d) << 7) | 32'(op), im > 32'hFFFFF, 1'b1);
      3'd4: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20) |
            (((im >> 12) & 255) << 12) | (32'(d) << 7) | 32'(op);
        push(w, (s < -1048576) || (s > 1048575) || (im % 2 == 1), 1'b1);
      end
      3'd5: begin
        lo = im & 32'hFFF;
        if (s >= -2048 && s <= 2047) begin
          push((lo << 20) | (32'(d) << 7) | 32'h13, 1'b0, 1'b1);
        end else begin
          hi = (im + 32'h800) >> 12;
          push((hi << 12) | (32'(d) << 7) | 32'h37, 1'b0, lo == 0);
          if (lo != 0) push((lo << 20) | (32'(d) << 15) | (32'(d) << 7) | 32'h13, 1'b0, 1'b1);
        end
      end
      default: push(32'h0, 1'b1, 1'b1);
    endcase
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [31:0] im);
    bit done;
    done = 1'b0;
    @(negedge clk);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      #4;
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sbq.size() != 0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    check("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk);
  endtask

  always @(negedge clk)
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);

  // Monitor: pops on every consumed word and checks stability under backpressure.
  logic        held_v = 1'b0;
  logic [33:0] held;
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("hold", {out_valid, inst, err, last}, {1'b1, held});
      held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %h expected no output", {inst, err, last});
        end else begin
          check("word", {inst, err, last}, sbq.pop_front());
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = {inst, err, last};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] edges[8];
    logic [31:0] im;
    edges = '{32'h0, 32'h7FF, 32'hFFFFF800, 32'h800, 32'hFFFFF7FF,
              32'h7FFFF800, 32'hFFE, 32'hFFF00000};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_err_last", {62'd0, err, last}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    push(32'hFFF30293, 1'b0, 1'b1);  send(3'd0, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF);
    push(32'hFE208EE3, 1'b0, 1'b1);  send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC);
    push(32'h00208163, 1'b1, 1'b1);  send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    push(32'h001000EF, 1'b0, 1'b1);  send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
    push(32'h800000EF, 1'b1, 1'b1);  send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00100000);
    push(32'h0, 1'b1, 1'b1);         send(3'd7, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0);
    push(32'h12346537, 1'b0, 1'b0);
    push(32'hFFF50513, 1'b0, 1'b1);  send(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
    check("li_in_ready_low", 64'(in_ready), 64'd0);
    push(32'h00500093, 1'b0, 1'b1);  send(3'd5, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    push(32'h000010B7, 1'b0, 1'b1);  send(3'd5, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00001000);
    push(32'h800001B7, 1'b0, 1'b0);
    push(32'h80018193, 1'b0, 1'b1);  send(3'd5, 7'h00, 5'd3, 5'd0, 5'd0, 3'd0, 32'h7FFFF800);
    drain();

    // Backpressure on the LUI half, then reset before the ADDI can appear.
    @(negedge clk);
    out_ready = 1'b0;
    send(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #4;
      check("bp_inst", {31'd0, out_valid, inst}, {31'd0, 1'b1, 32'h12346537});
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #4;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(posedge clk);

    rdy_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [2:0] f;
      logic [4:0] d, s1, s2;
      logic [2:0] f3;
      logic [6:0] op;
      f  = 3'($urandom_range(0, 7));
      d  = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
      f3 = 3'($urandom); op = 7'($urandom);
      case ($urandom_range(0, 3))
        0: im = $urandom;
        1: im = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: im = edges[$urandom_range(0, 7)];
        default: im = 32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000;
      endcase
      model_push(f, op, d, s1, s2, f3, im);
      send(f, op, d, s1, s2, f3, im);
    end
    drain();
    rdy_rand = 1'b0;
    out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
